// File: rtl/memory_autoplayer.sv
// Autoplayer for the LED memory game: captures one-hot LED steps while the game
// shows a pattern, then replays them as timed switch press/release pulses.
module memory_autoplayer #(
  parameter int unsigned CLK_PER_SEC  = 50000000,
  parameter int unsigned MAX_STEPS    = 16,
  parameter int unsigned IDLE_TIMEOUT = CLK_PER_SEC,
  parameter int unsigned PRESS_CYCLES = CLK_PER_SEC / 8,
  parameter int unsigned GAP_CYCLES   = CLK_PER_SEC / 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic [3:0]                   i_led,
  output logic [3:0]                   o_sw,
  output logic                         o_busy,
  output logic [$clog2(MAX_STEPS):0]   o_count,
  output logic                         o_round_done,
  output logic                         o_overflow
);

  localparam int unsigned IW     = $clog2(MAX_STEPS);
  localparam int unsigned CW     = IW + 1;
  localparam int unsigned PG_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int unsigned T_MAX  = (IDLE_TIMEOUT > PG_MAX) ? IDLE_TIMEOUT : PG_MAX;
  localparam int unsigned TW     = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] IDLE_LAST  = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] PRESS_LAST = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(MAX_STEPS);

  localparam logic [1:0] S_LISTEN = 2'd0;
  localparam logic [1:0] S_PRESS  = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_led;
  logic [TW-1:0] r_timer;
  logic [IW-1:0] r_idx;
  logic [1:0]    r_buf [MAX_STEPS];

  logic [1:0]    w_state_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic [IW-1:0] w_idx_nxt;
  logic [3:0]    w_sw_nxt;
  logic          w_busy_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_done_nxt;
  logic          w_ovf_nxt;
  logic          w_wr_en;
  logic          w_capture;
  logic [1:0]    w_led_id;
  logic          w_last;
  logic [IW-1:0] w_idx_inc;

  function automatic logic [1:0] f_led_id(input logic [3:0] v);
    logic [1:0] id;
    id = 2'd0;
    if (v[1]) id = 2'd1;
    if (v[2]) id = 2'd2;
    if (v[3]) id = 2'd3;
    return id;
  endfunction

  function automatic logic [3:0] f_sw_of(input logic [1:0] id);
    logic [3:0] sw;
    case (id)
      2'd0:    sw = 4'b0001;
      2'd1:    sw = 4'b0010;
      2'd2:    sw = 4'b0100;
      default: sw = 4'b1000;
    endcase
    return sw;
  endfunction

  // A step is a zero-to-one-hot LED edge; holding or hopping between LEDs is not.
  assign w_capture = (r_led == 4'b0000) && $onehot(i_led);
  assign w_led_id  = f_led_id(i_led);
  assign w_last    = ({1'b0, r_idx} == (o_count - CW'(1)));
  assign w_idx_inc = r_idx + IW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_sw_nxt    = o_sw;
    w_busy_nxt  = o_busy;
    w_count_nxt = o_count;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = o_overflow;
    w_wr_en     = 1'b0;

    if (!i_en) begin
      w_state_nxt = S_LISTEN;
      w_timer_nxt = '0;
      w_idx_nxt   = '0;
      w_sw_nxt    = 4'b0000;
      w_busy_nxt  = 1'b0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        S_LISTEN: begin
          if (w_capture) begin
            if (o_count == COUNT_FULL) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_wr_en     = 1'b1;
              w_count_nxt = o_count + CW'(1);
            end
          end
          // Idle timer saturates at its limit when nothing has been captured.
          if (i_led != 4'b0000) begin
            w_timer_nxt = '0;
          end else if (r_timer == IDLE_LAST) begin
            if (o_count != '0) begin
              w_state_nxt = S_PRESS;
              w_timer_nxt = '0;
              w_idx_nxt   = '0;
              w_sw_nxt    = f_sw_of(r_buf[0]);
              w_busy_nxt  = 1'b1;
            end
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end

        S_PRESS: begin
          if (r_timer == PRESS_LAST) begin
            w_state_nxt = S_GAP;
            w_timer_nxt = '0;
            w_sw_nxt    = 4'b0000;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end

        S_GAP: begin
          if (r_timer == GAP_LAST) begin
            w_timer_nxt = '0;
            if (w_last) begin
              w_state_nxt = S_LISTEN;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_count_nxt = '0;
            end else begin
              w_state_nxt = S_PRESS;
              w_idx_nxt   = w_idx_inc;
              w_sw_nxt    = f_sw_of(r_buf[w_idx_inc]);
            end
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end

        default: begin
          w_state_nxt = S_LISTEN;
          w_timer_nxt = '0;
          w_sw_nxt    = 4'b0000;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_LISTEN;
      r_led        <= 4'b0000;
      r_timer      <= '0;
      r_idx        <= '0;
      o_sw         <= 4'b0000;
      o_busy       <= 1'b0;
      o_count      <= '0;
      o_round_done <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_led        <= i_led;
      r_timer      <= w_timer_nxt;
      r_idx        <= w_idx_nxt;
      o_sw         <= w_sw_nxt;
      o_busy       <= w_busy_nxt;
      o_count      <= w_count_nxt;
      o_round_done <= w_done_nxt;
      o_overflow   <= w_ovf_nxt;
    end
  end

  // Step buffer holds data only; validity is tracked by o_count.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_buf[o_count[IW-1:0]] <= w_led_id;
    end
  end

endmodule

// File: tb/tb_memory_autoplayer.sv
// Bench for memory_autoplayer: queue-based step/replay model checked every cycle,
// directed LED scenarios with literal expectations, and a small closed-loop game.
module tb_memory_autoplayer;

  localparam int unsigned MAX   = 4;
  localparam int unsigned IDLE  = 20;
  localparam int unsigned PRESS = 4;
  localparam int unsigned GAP   = 3;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_en  = 1'b1;
  logic [3:0] i_led = 4'b0000;
  logic [3:0] o_sw;
  logic       o_busy;
  logic [2:0] o_count;
  logic       o_round_done;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;

  memory_autoplayer #(
    .CLK_PER_SEC (160),
    .MAX_STEPS   (MAX),
    .IDLE_TIMEOUT(IDLE),
    .PRESS_CYCLES(PRESS),
    .GAP_CYCLES  (GAP)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_led       (i_led),
    .o_sw        (o_sw),
    .o_busy      (o_busy),
    .o_count     (o_count),
    .o_round_done(o_round_done),
    .o_overflow  (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: captured ids in a queue; a replay is a precomputed per-cycle output list.
  typedef struct packed {
    logic [3:0] sw;
    logic       busy;
    logic       done;
  } ent_t;

  int unsigned caps[$];
  ent_t        sched[$];
  logic [3:0]  m_sw    = 4'b0000;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic        m_ovf   = 1'b0;
  int          m_count = 0;
  int          m_idle  = 0;
  logic [3:0]  m_prev  = 4'b0000;

  task automatic pop_entry();
    ent_t e;
    e      = sched.pop_front();
    m_sw   = e.sw;
    m_busy = e.busy;
    m_done = e.done;
    if (e.done) begin
      caps.delete();
      m_count = 0;
    end
  endtask

  task automatic build_replay();
    ent_t e;
    foreach (caps[i]) begin
      for (int c = 0; c < int'(PRESS); c++) begin
        e.sw = 4'(1 << caps[i]); e.busy = 1'b1; e.done = 1'b0;
        sched.push_back(e);
      end
      for (int c = 0; c < int'(GAP); c++) begin
        e.sw = 4'b0000; e.busy = 1'b1; e.done = 1'b0;
        sched.push_back(e);
      end
    end
    e.sw = 4'b0000; e.busy = 1'b0; e.done = 1'b1;
    sched.push_back(e);
  endtask

  initial begin : model
    forever begin
      @(posedge i_clk or posedge i_rst);
      if (i_rst) begin
        caps.delete(); sched.delete();
        m_sw = 4'b0000; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
        m_count = 0; m_idle = 0; m_prev = 4'b0000;
      end else begin
        m_done = 1'b0;
        if (!i_en) begin
          caps.delete(); sched.delete();
          m_sw = 4'b0000; m_busy = 1'b0; m_count = 0; m_idle = 0;
        end else if (sched.size() > 0) begin
          pop_entry();
        end else begin
          if (m_prev == 4'b0000 && $countones(i_led) == 1) begin
            if (caps.size() < MAX) begin
              for (int b = 0; b < 4; b++) if (i_led[b]) caps.push_back(b);
            end else begin
              m_ovf = 1'b1;
            end
          end
          m_count = caps.size();
          if (i_led != 4'b0000) begin
            m_idle = 0;
          end else if (m_idle == int'(IDLE) - 1) begin
            if (caps.size() > 0) begin
              m_idle = 0;
              build_replay();
              pop_entry();
            end
          end else begin
            m_idle++;
          end
        end
        m_prev = i_led;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge i_clk);
      chk("sw",         32'(o_sw),         32'(m_sw));
      chk("busy",       32'(o_busy),       32'(m_busy));
      chk("count",      32'(o_count),      32'(m_count));
      chk("round_done", 32'(o_round_done), 32'(m_done));
      chk("overflow",   32'(o_overflow),   32'(m_ovf));
      if ($countones(o_sw) > 1) chk("sw_onehot", 32'($countones(o_sw)), 32'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic show(input logic [3:0] v, input int n);
    i_led = v;
    tick(n);
  endtask

  logic [3:0] seq2 [3];
  logic [3:0] prev_sw;
  int         presses;
  int         gap_len;
  int         pat [3];
  logic [3:0] score;
  int         pidx;
  bit         seen_done;

  initial begin : stim
    seq2[0] = 4'b0001; seq2[1] = 4'b0100; seq2[2] = 4'b1000;
    pat[0] = 2; pat[1] = 0; pat[2] = 3;

    // Reset, then a reset landing mid-press.
    tick(3);
    i_rst = 1'b0;
    tick(2);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_ovf",   32'(o_overflow), 32'd0);
    show(4'b0100, 2);
    show(4'b0000, 20);
    chk("t1_press_sw",   32'(o_sw), 32'h4);
    chk("t1_press_busy", 32'(o_busy), 32'd1);
    tick(1);
    i_rst = 1'b1;
    #1;
    chk("t1_async_sw",    32'(o_sw), 32'd0);
    chk("t1_async_count", 32'(o_count), 32'd0);
    chk("t1_async_busy",  32'(o_busy), 32'd0);
    tick(2);
    i_rst = 1'b0;
    tick(25);
    chk("t1_listen_busy", 32'(o_busy), 32'd0);

    // Three-step pattern and its exact replay waveform.
    show(4'b0001, 5); show(4'b0000, 5);
    show(4'b0100, 5); show(4'b0000, 5);
    show(4'b1000, 5); show(4'b0000, 19);
    chk("t2_count", 32'(o_count), 32'd3);
    chk("t2_idle_busy", 32'(o_busy), 32'd0);
    for (int k = 0; k < 21; k++) begin
      tick(1);
      chk("t2_replay_sw", 32'(o_sw), ((k % 7) < 4) ? 32'(seq2[k / 7]) : 32'd0);
    end
    tick(1);
    chk("t2_done",       32'(o_round_done), 32'd1);
    chk("t2_done_count", 32'(o_count), 32'd0);
    tick(1);
    chk("t2_done_pulse", 32'(o_round_done), 32'd0);

    // Repeated step gives two separate presses.
    show(4'b0010, 5); show(4'b0000, 5);
    show(4'b0010, 5); show(4'b0000, 19);
    chk("t3_count", 32'(o_count), 32'd2);
    prev_sw = 4'b0000; presses = 0; gap_len = 0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (prev_sw == 4'b0000 && o_sw == 4'b0010) presses++;
      if (presses == 1 && o_sw == 4'b0000) gap_len++;
      prev_sw = o_sw;
    end
    chk("t3_presses", 32'(presses), 32'd2);
    chk("t3_gap",     32'(gap_len), 32'd3);

    // Multi-hot and direct LED hops never capture.
    show(4'b0011, 5); show(4'b0001, 3); show(4'b0010, 3);
    chk("t4_count", 32'(o_count), 32'd0);
    show(4'b0000, 25);
    chk("t4_no_replay", 32'(o_busy), 32'd0);

    // Overflow: fifth capture dropped; flag sticky across en low, cleared by reset.
    show(4'b0001, 3); show(4'b0000, 2);
    show(4'b0010, 3); show(4'b0000, 2);
    show(4'b0100, 3); show(4'b0000, 2);
    show(4'b1000, 3); show(4'b0000, 2);
    show(4'b0001, 3); show(4'b0000, 19);
    chk("t5_count", 32'(o_count), 32'd4);
    chk("t5_ovf",   32'(o_overflow), 32'd1);
    tick(29);
    chk("t5_done", 32'(o_round_done), 32'd1);
    chk("t5_ovf_kept", 32'(o_overflow), 32'd1);
    show(4'b0100, 3); show(4'b0000, 20);
    tick(2);
    chk("t5_mid_press", 32'(o_sw), 32'h4);
    i_en = 1'b0;
    tick(1);
    chk("t5_en_sw",    32'(o_sw), 32'd0);
    chk("t5_en_count", 32'(o_count), 32'd0);
    chk("t5_en_ovf",   32'(o_overflow), 32'd1);
    i_en = 1'b1;
    tick(2);
    i_rst = 1'b1;
    #1;
    chk("t5_rst_ovf", 32'(o_overflow), 32'd0);
    tick(1);
    i_rst = 1'b0;
    tick(3);

    // Closed loop: game shows growing prefixes and judges the echoed presses.
    score = 4'h0;
    for (int r = 1; r <= 3; r++) begin
      for (int s = 0; s < r; s++) begin
        show(4'(1 << pat[s]), 5);
        show(4'b0000, 3);
      end
      prev_sw = 4'b0000; pidx = 0; seen_done = 1'b0;
      for (int c = 0; c < 300 && !seen_done; c++) begin
        tick(1);
        if (prev_sw != 4'b0000 && o_sw == 4'b0000) begin
          if (pidx >= r || prev_sw != 4'(1 << pat[pidx])) score = 4'hF;
          pidx++;
        end
        if (o_round_done) seen_done = 1'b1;
        prev_sw = o_sw;
        i_led   = o_sw;
      end
      chk("t6_round_done", 32'(seen_done), 32'd1);
      chk("t6_presses",    32'(pidx), 32'(r));
      if (score != 4'hF) score = (r == 3) ? 4'hA : 4'(r);
      i_led = 4'b0000;
      tick(2);
    end
    chk("t6_score", 32'(score), 32'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_autoplayer.md
Name: memory_autoplayer

Overview:
- Automated player for the LED memory game; drives the game's switch inputs and watches its LED outputs.
- Captures each pattern step the game shows on the LEDs. Once the display goes quiet, it replays the captured sequence as timed switch press/release pulses.
- Used for hands-free demo mode and for closed-loop regression of the game state machine.

Parameters:
- CLK_PER_SEC, 50000000, clock cycles per second.
- MAX_STEPS, 16, capture buffer depth in steps (power of two, >=2).
- IDLE_TIMEOUT, CLK_PER_SEC, consecutive all-off LED cycles that end the listen phase.
- PRESS_CYCLES, CLK_PER_SEC/8, cycles a switch is held high per replayed step (>=1).
- GAP_CYCLES, CLK_PER_SEC/8, cycles all switches are low after each release (>=1).

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous active-high reset
- i_en  in  1  autoplay enable; low forces LISTEN with the buffer cleared
- i_led  in  4  game LED outputs, same clock domain
- o_sw  out  4  switch drive to the game, at most one bit high
- o_busy  out  1  high in PRESS or GAP
- o_count  out  $clog2(MAX_STEPS)+1  number of steps captured this round
- o_round_done  out  1  one-cycle pulse after the final GAP of a replay
- o_overflow  out  1  sticky: a capture arrived with the buffer full

Behaviour:
- Reset (asynchronous), and also i_en low (synchronous):
  - state LISTEN; o_sw=0; o_count=0; o_busy=0; o_round_done=0; timers=0.
  - o_overflow is cleared by reset only; i_en low does not clear it.
- i_led is registered once (r_led) for edge detection.
- Capture event: r_led==4'b0000 and i_led is one-hot.
  - Stored id is the index of the high bit (bit0->0 ... bit3->3).
  - Store at address o_count, then increment o_count.
  - Multi-hot or zero->non-one-hot transitions are ignored.
  - Holding the same one-hot value does not re-capture.
- States:
  - LISTEN:
    - Capture events as above.
    - Idle timer counts cycles with i_led==0 and resets to 0 on any nonzero i_led.
    - When the timer reaches IDLE_TIMEOUT-1 with o_count>0: go to PRESS, replay index=0, timer=0.
    - With o_count==0 the timer saturates; the state stays LISTEN.
    - Capture when o_count==MAX_STEPS: data is dropped, o_overflow set, o_count unchanged.
  - PRESS:
    - o_sw = one-hot of buf[index], registered and valid the first PRESS cycle.
    - After PRESS_CYCLES cycles: go to GAP, o_sw=0. The game registers the step on this falling edge.
  - GAP:
    - o_sw=0 for GAP_CYCLES cycles.
    - Then, if index==o_count-1: pulse o_round_done, clear o_count, return to LISTEN.
    - Otherwise: index+1, back to PRESS.
- i_led is ignored entirely in PRESS/GAP, because the game echoes switches onto its LEDs.
- i_en falling mid-replay: the next edge forces LISTEN, o_sw=0, buffer cleared. A partial press is cut short and the game sees it as a press.
- Reset mid-replay: o_sw drops to 0 immediately (asynchronous).
- A new round is recaptured from scratch; the game re-shows the full prefix each round, so no prefix reuse is needed.
- Counters are sized $clog2(max(IDLE_TIMEOUT,PRESS_CYCLES,GAP_CYCLES))+1 and never wrap.
- Only one o_sw bit is ever high. o_sw is driven from flops only, with no combinational path from i_led.

Test Plan:
Test parameters: IDLE_TIMEOUT=20, PRESS_CYCLES=4, GAP_CYCLES=3, MAX_STEPS=4.
1. Reset asserted mid-PRESS -> o_sw=0 in the same cycle, o_count=0, o_busy=0. After release, state is LISTEN.
2. LED sequence 0001,0000,0100,0000,1000, each 5 cycles, then 20 zero cycles:
   - o_count=3.
   - o_sw shows 0001 x4, 0000 x3, 0100 x4, 0000 x3, 1000 x4, 0000 x3, then one o_round_done pulse with o_count=0.
3. Repeated step 0010,0000,0010: two captures, replayed as two separate 0010 presses with a 3-cycle gap between them.
4. Multi-hot 0011 and direct 0001->0010 transitions -> no capture; o_count unchanged.
5. Five one-hot captures with MAX_STEPS=4 -> o_count=4, o_overflow=1. Replay is the first 4 ids only; o_overflow stays set until i_rst.
6. Closed loop with the game (GAME_LIMIT=3, scaled CLK_PER_SEC) -> game score reaches 4'hA (WIN), never 4'hF.
